// File: rtl/lsu_axi_req.sv
// lsu_axi_req -- load/store unit request engine between EXU and WBU.
//
// Accepts one memory request at a time from the EXU and turns it into AXI4-Lite
// master traffic. Loads use AR/R and return byte/half/word/dword data with sign or
// zero extension. Stores use AW/W/B with the data shifted onto its byte lanes and a
// matching WSTRB. Misaligned or illegal-size requests finish without bus traffic.
// Bus errors and timeouts are reported in rsp_err and never stall the unit.
//
// Ports
//   clock, reset               rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready        EXU request handshake (ready only in IDLE)
//   req_we, req_addr, req_size request kind, byte address, size (0 B, 1 H, 2 W, 3 D)
//   req_signed, req_wdata      load sign-extension flag, right-aligned store data
//   rsp_valid/rsp_ready        WBU result handshake
//   rsp_rdata, rsp_err         extended load data; 0 ok, 1 misaligned/size, 2 bus, 3 timeout
//   ar*/r*                     AXI read address and read data channels
//   aw*/w*/b*                  AXI write address, write data and write response channels
module lsu_axi_req #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int TMR_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_r;
  logic [TMR_W-1:0] timer_r;
  logic [OFF_W-1:0] off_r;
  logic [1:0]       size_r;
  logic             sgn_r;

  logic [OFF_W-1:0]  req_off_s;
  logic [ADDR_W-1:0] req_addr_aligned_s;
  logic [TMR_W-1:0]  timer_inc_s;
  logic              timeout_hit_s;
  logic              aw_done_s;
  logic              w_done_s;
  logic              unused_bits_s;

  // Request is misaligned when the offset is not a multiple of the access size,
  // or the access is wider than the bus.
  function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
    logic [OFF_W-1:0] low_mask;
    case (size)
      2'd0:    low_mask = '0;
      2'd1:    low_mask = OFF_W'(3'd1);
      2'd2:    low_mask = OFF_W'(3'd3);
      default: low_mask = OFF_W'(3'd7);
    endcase
    return (int'(size) > OFF_W) || ((off & low_mask) != '0);
  endfunction

  // Byte-lane enables for an access of the given size at the given offset.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [OFF_W-1:0] off, input logic [1:0] size);
    logic [STRB_W-1:0] base;
    case (size)
      2'd0:    base = STRB_W'(8'h01);
      2'd1:    base = STRB_W'(8'h03);
      2'd2:    base = STRB_W'(8'h0F);
      default: base = '1;
    endcase
    return base << off;
  endfunction

  // Pull the addressed lane down to bit 0, then zero- or sign-extend it.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic              sgn);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              msb;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = DATA_W'(8'hFF);         msb = sh[7];        end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      msb = sh[15];       end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); msb = sh[31];       end
      default: begin mask = '1;                     msb = sh[DATA_W-1]; end
    endcase
    return (sgn && msb) ? ((sh & mask) | ~mask) : (sh & mask);
  endfunction

  assign req_ready          = (state_r == IDLE);
  assign req_off_s          = req_addr[OFF_W-1:0];
  assign req_addr_aligned_s = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign timer_inc_s        = timer_r + TMR_W'(1'b1);
  assign timeout_hit_s      = (TIMEOUT_CYC != 0) && (timer_inc_s == TMR_W'(TIMEOUT_CYC));
  // A write channel counts as done once its valid has already been dropped or it
  // handshakes this cycle, so AW and W may complete in either order.
  assign aw_done_s          = !awvalid || awready;
  assign w_done_s           = !wvalid || wready;
  // Only bit 1 of a response distinguishes error from success.
  assign unused_bits_s      = ^{rresp[0], bresp[0]};

  // Request sequencer: owns every bus and response output as a register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      off_r     <= '0;
      size_r    <= 2'd0;
      sgn_r     <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            off_r   <= req_off_s;
            size_r  <= req_size;
            sgn_r   <= req_signed;
            timer_r <= '0;
            if (misaligned(req_off_s, req_size)) begin
              state_r   <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'd1;
              rsp_rdata <= '0;
            end else if (req_we) begin
              state_r <= WR_REQ;
              awaddr  <= req_addr_aligned_s;
              awvalid <= 1'b1;
              wdata   <= req_wdata << {req_off_s, 3'b000};
              wstrb   <= lane_strb(req_off_s, req_size);
              wvalid  <= 1'b1;
            end else begin
              state_r <= RD_ADDR;
              araddr  <= req_addr_aligned_s;
              arvalid <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          if (arready) begin
            state_r <= RD_DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            timer_r <= '0;
          end else if (timeout_hit_s) begin
            state_r   <= DONE;
            arvalid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'd3;
            rsp_rdata <= '0;
          end else begin
            timer_r <= timer_inc_s;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            state_r   <= DONE;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            if (rresp[1]) begin
              rsp_err   <= 2'd2;
              rsp_rdata <= '0;
            end else begin
              rsp_err   <= 2'd0;
              rsp_rdata <= extend_load(rdata, off_r, size_r, sgn_r);
            end
          end else if (timeout_hit_s) begin
            state_r   <= DONE;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'd3;
            rsp_rdata <= '0;
          end else begin
            timer_r <= timer_inc_s;
          end
        end

        WR_REQ: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            state_r <= WR_RESP;
            bready  <= 1'b1;
            timer_r <= '0;
          end else if (timeout_hit_s) begin
            state_r   <= DONE;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'd3;
            rsp_rdata <= '0;
          end else begin
            timer_r <= timer_inc_s;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            state_r   <= DONE;
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= bresp[1] ? 2'd2 : 2'd0;
            rsp_rdata <= '0;
          end else if (timeout_hit_s) begin
            state_r   <= DONE;
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'd3;
            rsp_rdata <= '0;
          end else begin
            timer_r <= timer_inc_s;
          end
        end

        DONE: begin
          // Result stays frozen until the WBU takes it.
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: begin
          state_r   <= IDLE;
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          bready    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_req.sv
// Self-checking bench for lsu_axi_req (DATA_W=32, TIMEOUT_CYC=8).
// A negedge-driven AXI slave with per-channel wait knobs answers the DUT; every
// request pushes its expected result onto a scoreboard queue that a monitor pops
// when the response handshake occurs.
module tb_lsu_axi_req;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  lsu_axi_req #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // ---------------- slave model ----------------
  int          slv_ar_wait = 0, slv_aw_wait = 0, slv_w_wait = 0;
  bit          slv_r_en = 1'b1, slv_b_en = 1'b1;
  logic [31:0] slv_rdata = 32'h0;
  logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
  bit          r_pend, b_pend, aw_got, w_got, ar_fire, aw_fire, w_fire, r_fire, b_fire;
  int          ar_cnt, aw_cnt, w_cnt;
  int          n_b = 0, n_arv = 0, n_awv = 0;

  // Outputs set here are what the DUT samples at the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
      rdata = 32'h0; rresp = 2'b00; bresp = 2'b00;
      r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      ar_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; r_fire = 1'b0; b_fire = 1'b0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (r_fire) rvalid = 1'b0;
      if (b_fire) bvalid = 1'b0;
      if (ar_fire) r_pend = 1'b1;
      if (aw_fire) aw_got = 1'b1;
      if (w_fire) w_got = 1'b1;
      if (aw_got && w_got) begin b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
      if (r_pend && slv_r_en && !rvalid) begin
        rvalid = 1'b1; rdata = slv_rdata; rresp = slv_rresp; r_pend = 1'b0;
      end
      if (b_pend && slv_b_en && !bvalid) begin
        bvalid = 1'b1; bresp = slv_bresp; b_pend = 1'b0;
      end
      arready = arvalid && (ar_cnt >= slv_ar_wait);
      ar_cnt  = (arvalid && !arready) ? ar_cnt + 1 : 0;
      awready = awvalid && (aw_cnt >= slv_aw_wait);
      aw_cnt  = (awvalid && !awready) ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= slv_w_wait);
      w_cnt   = (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_fire = arvalid && arready;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      r_fire  = rvalid && rready;
      b_fire  = bvalid && bready;
      if (b_fire) n_b++;
      if (arvalid) n_arv++;
      if (awvalid || wvalid) n_awv++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb_q[$];
  bit   seen = 1'b0;
  int   rise_cyc = 0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      seen = 1'b0;
    end else begin
      if (!rsp_valid) seen = 1'b0;
      if (rsp_valid && !seen) begin seen = 1'b1; rise_cyc = cyc; end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_rdata"}, rsp_rdata, e.rdata);
          check({e.name, "_err"}, rsp_err, e.err);
          if (e.lat > 0) check({e.name, "_latency"}, rise_cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic send(input string name, input bit we, input logic [31:0] addr,
                      input logic [1:0] size, input bit sgn, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic [1:0] exp_err, input int lat);
    int   guard;
    exp_t e;
    @(negedge clock);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clock); guard++; end
    check({name, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    e.name = name; e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 60) begin @(negedge clock); guard++; end
    if (sb_q.size() != 0) begin
      check({name, "_no_response"}, 64'd0, 64'd1);
      sb_q.delete();
    end
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    string name; logic [31:0] addr; logic [1:0] size; bit sgn;
    logic [31:0] rd; logic [1:0] rr; logic [31:0] exp; logic [1:0] err;
  } ld_t;
  ld_t loads[9] = '{
    '{"lw",        32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'd0},
    '{"lb_s",      32'h8000_0013, 2'd0, 1'b1, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 2'd0},
    '{"lbu",       32'h8000_0013, 2'd0, 1'b0, 32'h80FF_FFFF, 2'b00, 32'h0000_0080, 2'd0},
    '{"lh_s",      32'h8000_0102, 2'd1, 1'b1, 32'hF00D_1234, 2'b00, 32'hFFFF_F00D, 2'd0},
    '{"lhu",       32'h8000_0102, 2'd1, 1'b0, 32'hF00D_1234, 2'b00, 32'h0000_F00D, 2'd0},
    '{"lb_s_pos",  32'h8000_0001, 2'd0, 1'b1, 32'h1234_7F56, 2'b00, 32'h0000_007F, 2'd0},
    '{"lw_exokay", 32'h8000_0008, 2'd2, 1'b0, 32'h0BAD_CAFE, 2'b01, 32'h0BAD_CAFE, 2'd0},
    '{"lw_slverr", 32'h8000_000C, 2'd2, 1'b0, 32'h5555_5555, 2'b10, 32'h0000_0000, 2'd2},
    '{"lw_decerr", 32'h8000_0010, 2'd2, 1'b0, 32'h6666_6666, 2'b11, 32'h0000_0000, 2'd2}
  };

  typedef struct {
    string name; logic [31:0] addr; logic [1:0] size; logic [31:0] wd;
    int aw_wait; int w_wait; logic [1:0] br;
    logic [3:0] strb; logic [31:0] wexp; logic [1:0] err; int lat;
  } st_t;
  st_t stores[5] = '{
    '{"sw",        32'h8000_0040, 2'd2, 32'hCAFE_F00D, 0, 0, 2'b00, 4'b1111, 32'hCAFE_F00D, 2'd0, 3},
    '{"sb",        32'h8000_0041, 2'd0, 32'h0000_00AB, 0, 0, 2'b00, 4'b0010, 32'h0000_AB00, 2'd0, 3},
    '{"sh_w_first",32'h8000_0022, 2'd1, 32'h0000_1234, 2, 0, 2'b00, 4'b1100, 32'h1234_0000, 2'd0, 5},
    '{"sh_aw_first",32'h8000_0030,2'd1, 32'h0000_BEEF, 0, 2, 2'b01, 4'b0011, 32'h0000_BEEF, 2'd0, 5},
    '{"sw_slverr", 32'h8000_0080, 2'd2, 32'h55AA_55AA, 0, 0, 2'b10, 4'b1111, 32'h55AA_55AA, 2'd2, 3}
  };

  typedef struct { string name; bit we; logic [31:0] addr; logic [1:0] size; } mis_t;
  mis_t mis[5] = '{
    '{"mis_lw",  1'b0, 32'h8000_0002, 2'd2},
    '{"mis_lh",  1'b0, 32'h8000_0001, 2'd1},
    '{"mis_ld",  1'b0, 32'h8000_0000, 2'd3},
    '{"mis_sw",  1'b1, 32'h8000_0003, 2'd2},
    '{"mis_sd",  1'b1, 32'h8000_0008, 2'd3}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, cnt, b0, arv0, awv0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 2'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("rst_req_ready", req_ready, 1'b1);

    // Loads, zero-wait slave
    foreach (loads[i]) begin
      slv_rdata = loads[i].rd; slv_rresp = loads[i].rr;
      send(loads[i].name, 1'b0, loads[i].addr, loads[i].size, loads[i].sgn, 32'h0,
           loads[i].exp, loads[i].err, 3);
      check({loads[i].name, "_araddr"}, araddr, loads[i].addr & 32'hFFFF_FFFC);
      check({loads[i].name, "_arvalid"}, arvalid, 1'b1);
      drain(loads[i].name);
    end
    slv_rresp = 2'b00;

    // Stores, including AW/W skew in both directions
    foreach (stores[i]) begin
      slv_aw_wait = stores[i].aw_wait; slv_w_wait = stores[i].w_wait; slv_bresp = stores[i].br;
      b0 = n_b;
      send(stores[i].name, 1'b1, stores[i].addr, stores[i].size, 1'b0, stores[i].wd,
           32'h0, stores[i].err, stores[i].lat);
      check({stores[i].name, "_wstrb"}, wstrb, stores[i].strb);
      check({stores[i].name, "_wdata"}, wdata, stores[i].wexp);
      check({stores[i].name, "_awaddr"}, awaddr[31:2], stores[i].addr[31:2]);
      @(posedge clock); #1;
      if (stores[i].aw_wait != stores[i].w_wait) begin
        check({stores[i].name, "_awvalid_split"}, awvalid, stores[i].aw_wait > stores[i].w_wait);
        check({stores[i].name, "_wvalid_split"}, wvalid, stores[i].w_wait > stores[i].aw_wait);
      end
      drain(stores[i].name);
      check({stores[i].name, "_b_count"}, n_b - b0, 1);
    end
    slv_aw_wait = 0; slv_w_wait = 0; slv_bresp = 2'b00;

    // Misaligned / illegal size: 1-cycle error, no bus traffic
    arv0 = n_arv; awv0 = n_awv;
    foreach (mis[i]) begin
      send(mis[i].name, mis[i].we, mis[i].addr, mis[i].size, 1'b0, 32'hFFFF_FFFF,
           32'h0, 2'd1, 1);
      drain(mis[i].name);
    end
    check("mis_no_ar", n_arv - arv0, 0);
    check("mis_no_aw_w", n_awv - awv0, 0);

    // Response backpressure: result held stable, no new request accepted
    rsp_ready = 1'b0;
    slv_rdata = 32'h1122_3344;
    send("bp_lw", 1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0, 32'h1122_3344, 2'd0, 3);
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clock); guard++; end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_rdata", rsp_rdata, 32'h1122_3344);
      check("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    drain("bp_lw");

    // Read timeout: rready held exactly TO cycles, then err 3
    slv_r_en = 1'b0;
    send("to_lw", 1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'h0, 32'h0, 2'd3, 0);
    cnt = 0; guard = 0;
    while (guard < 40) begin
      @(negedge clock);
      if (rsp_valid) break;
      if (rready) cnt++;
      guard++;
    end
    check("to_rready_cycles", cnt, TO);
    check("to_rready_dropped", rready, 1'b0);
    drain("to_lw");

    // A late R beat in IDLE is ignored
    slv_r_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("late_r_rready", rready, 1'b0);
      check("late_r_rsp_valid", rsp_valid, 1'b0);
    end
    @(negedge clock) reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Asynchronous reset while waiting in RD_DATA
    slv_r_en = 1'b0;
    send("rst_mid", 1'b0, 32'h8000_0100, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 0);
    guard = 0;
    while (!rready && guard < 20) begin @(negedge clock); guard++; end
    check("rst_mid_in_rd_data", rready, 1'b1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("rst_mid_arvalid", arvalid, 1'b0);
    check("rst_mid_rready", rready, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    slv_r_en = 1'b1;

    // Normal operation resumes after the abort
    slv_rdata = 32'hA5A5_0F0F;
    send("post_rst_lw", 1'b0, 32'h8000_0200, 2'd2, 1'b0, 32'h0, 32'hA5A5_0F0F, 2'd0, 3);
    drain("post_rst_lw");

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
